// File: rtl/sine_uart_pkg.sv
// Shared types and constants for the sine generator UART controller.
// Command codes, frame bytes and the parser state enum.
package sine_uart_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] CMD_STEP_LO  = 8'h01;
  localparam logic [7:0] CMD_STEP_HI  = 8'h02;
  localparam logic [7:0] CMD_AMP      = 8'h03;
  localparam logic [7:0] CMD_RUN      = 8'h04;
  localparam logic [7:0] CMD_PRESC_LO = 8'h05;
  localparam logic [7:0] CMD_PRESC_HI = 8'h06;
  localparam logic [7:0] CMD_STATUS   = 8'h10;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    RESP
  } state_e;

endpackage

// File: rtl/sine_uart_if.sv
// Byte stream between the UART RX/TX pair and the command controller.
// master = UART side, slave = controller side.
interface sine_uart_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/sine_uart_ctrl_sample_prescaler.sv
// Sample-rate down-counter; one-cycle tick every presc+1 cycles.
// load and presc come straight from the register write path.
module sample_prescaler #(
  parameter logic [15:0] PRESC_RST = 16'd999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] presc,
  input  logic        load,
  input  logic        run,
  output logic        sample_tick
);

  logic [15:0] cnt_q, cnt_d;

  // a write or a stopped generator always restarts the period
  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (load || !run || cnt_q == 16'd0) begin
      cnt_d = presc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= PRESC_RST;
    else        cnt_q <= cnt_d;
  end

  assign sample_tick = run && (cnt_q == 16'd0);

endmodule

// File: rtl/sine_uart_ctrl.sv
// Frame parser, config register file and status responder for the
// PWM sine generator.
module sine_uart_ctrl
  import sine_uart_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] PRESC_RST      = 16'd999,
  parameter logic [15:0] STEP_RST       = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  sine_uart_if.slave  uart,
  output logic [15:0] step,
  output logic [1:0]  amp_shift,
  output logic        run,
  output logic        sample_tick
);

  localparam int GW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  step_sh_q, step_sh_d;
  logic [1:0]  amp_q, amp_d;
  logic        run_q, run_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  presc_sh_q, presc_sh_d;
  logic        presc_wr;
  logic        byte_ok;

  assign byte_ok = uart.rx_valid;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tx_data_d  = tx_data_q;
    gap_d      = gap_q;
    step_d     = step_q;
    step_sh_d  = step_sh_q;
    amp_d      = amp_q;
    run_d      = run_q;
    presc_d    = presc_q;
    presc_sh_d = presc_sh_q;
    presc_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_ok && uart.rx_data == HDR) begin
          state_d = CMD;
          gap_d   = '0;
        end
      end
      CMD, DATA: begin
        if (byte_ok) begin
          gap_d = '0;
          if (state_q == CMD) begin
            cmd_d   = uart.rx_data;
            state_d = DATA;
          end else begin
            state_d   = RESP;
            tx_data_d = ACK;
            case (cmd_q)
              CMD_STEP_LO:  step_sh_d = uart.rx_data;
              CMD_STEP_HI:  step_d = {uart.rx_data, step_sh_q};
              CMD_AMP:      amp_d = uart.rx_data[1:0];
              CMD_RUN:      run_d = uart.rx_data[0];
              CMD_PRESC_LO: presc_sh_d = uart.rx_data;
              CMD_PRESC_HI: begin
                presc_d  = {uart.rx_data, presc_sh_q};
                presc_wr = 1'b1;
              end
              CMD_STATUS:   tx_data_d = {run_q, amp_q, 5'b0};
              default:      tx_data_d = NAK;
            endcase
          end
        end else if (gap_q == GAP_MAX) begin
          // stale partial frame: drop silently
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RESP: begin
        if (uart.tx_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      gap_q      <= '0;
      step_q     <= STEP_RST;
      step_sh_q  <= 8'h00;
      amp_q      <= 2'd0;
      run_q      <= 1'b0;
      presc_q    <= PRESC_RST;
      presc_sh_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tx_data_q  <= tx_data_d;
      gap_q      <= gap_d;
      step_q     <= step_d;
      step_sh_q  <= step_sh_d;
      amp_q      <= amp_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      presc_sh_q <= presc_sh_d;
    end
  end

  sample_prescaler #(
    .PRESC_RST (PRESC_RST)
  ) u_presc (
    .clk         (clk),
    .rst_n       (rst_n),
    .presc       (presc_d),
    .load        (presc_wr),
    .run         (run_q),
    .sample_tick (sample_tick)
  );

  assign uart.tx_valid = (state_q == RESP);
  assign uart.tx_data  = tx_data_q;
  assign step          = step_q;
  assign amp_shift     = amp_q;
  assign run           = run_q;

endmodule

// File: tb/tb_sine_uart_ctrl.sv
// Randomized frame stimulus checked every cycle against a frame-level
// model, plus directed scenarios with literal expectations.
module tb_sine_uart_ctrl;

  localparam int T = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_uart_if bus();
  logic [15:0] step;
  logic [1:0]  amp_shift;
  logic        run;
  logic        sample_tick;

  sine_uart_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart        (bus),
    .step        (step),
    .amp_shift   (amp_shift),
    .run         (run),
    .sample_tick (sample_tick)
  );

  int total = 0;
  int bad = 0;
  bit rnd_rdy = 0;
  logic [7:0] got[$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [15:0] m_step = 16'h0100;
  logic [7:0]  m_ssh = 0;
  logic [1:0]  m_amp = 0;
  logic        m_run = 0;
  logic [15:0] m_presc = 16'd999;
  logic [7:0]  m_psh = 0;
  bit          m_resp = 0;
  logic [7:0]  m_tx = 0;
  logic [7:0]  fr[$];
  int n = 0, last = 0, t0 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step = 16'h0100; m_ssh = 0; m_amp = 0; m_run = 0;
      m_presc = 16'd999; m_psh = 0; m_resp = 0; m_tx = 0;
      fr.delete(); n = 0; last = 0; t0 = 0;
    end else begin
      n++;
      if (m_resp) begin
        if (bus.tx_ready) m_resp = 0;
      end else begin
        if (fr.size() > 0 && !bus.rx_valid && n - last >= T)
          fr.delete();
        if (bus.rx_valid) begin
          if (fr.size() == 0) begin
            if (bus.rx_data == 8'hA5) begin
              fr.push_back(bus.rx_data); last = n;
            end
          end else if (fr.size() == 1) begin
            fr.push_back(bus.rx_data); last = n;
          end else begin
            m_tx = 8'h06;
            case (fr[1])
              8'h01: m_ssh = bus.rx_data;
              8'h02: m_step = {bus.rx_data, m_ssh};
              8'h03: m_amp = bus.rx_data[1:0];
              8'h04: begin
                if (bus.rx_data[0] && !m_run) t0 = n;
                m_run = bus.rx_data[0];
              end
              8'h05: m_psh = bus.rx_data;
              8'h06: begin
                m_presc = {bus.rx_data, m_psh}; t0 = n;
              end
              8'h10: m_tx = {m_run, m_amp, 5'b0};
              default: m_tx = 8'h15;
            endcase
            m_resp = 1;
            fr.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("step", step, m_step);
      chk("amp", amp_shift, m_amp);
      chk("run", run, m_run);
      chk("tx_valid", bus.tx_valid, m_resp);
      if (m_resp) chk("tx_data", bus.tx_data, m_tx);
      chk("tick", sample_tick,
          m_run && ((n - t0) % (int'(m_presc) + 1) == int'(m_presc)));
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.tx_ready = ($urandom % 4) != 0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] d,
                       input int gmax);
    send(8'hA5);
    repeat ($urandom_range(0, gmax)) cyc();
    send(c);
    repeat ($urandom_range(0, gmax)) cyc();
    send(d);
  endtask

  task automatic wait_tx(output logic [7:0] r);
    int k0 = got.size();
    int i = 0;
    while (got.size() == k0 && i < 200) begin
      cyc();
      i++;
    end
    if (got.size() == k0) begin
      chk("resp_wait", 0, 1);
      r = 8'hxx;
    end else begin
      r = got[got.size() - 1];
    end
  endtask

  task automatic wait_tick(output longint c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        c = $time;
        break;
      end
    end
  endtask

  logic [7:0] r;
  longint ta, tb;
  int k;
  logic [7:0] c, d;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_step", step, 16'h0100);
    chk("rst_amp", amp_shift, 0);
    chk("rst_run", run, 0);
    chk("rst_txv", bus.tx_valid, 0);
    chk("rst_txd", bus.tx_data, 8'h00);
    chk("rst_tick", sample_tick, 0);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    frame(8'h04, 8'h01, 0);
    wait_tx(r);
    chk("run_ack", r, 8'h06);
    chk("run_on", run, 1);
    wait_tick(ta);
    wait_tick(tb);
    chk("tick_period", (tb - ta) / 10, 1000);

    frame(8'h01, 8'h34, 2);
    wait_tx(r);
    chk("lo_ack", r, 8'h06);
    chk("step_held", step, 16'h0100);
    frame(8'h02, 8'h12, 2);
    wait_tx(r);
    chk("hi_ack", r, 8'h06);
    chk("step_new", step, 16'h1234);

    frame(8'h7E, 8'h00, 1);
    wait_tx(r);
    chk("nak", r, 8'h15);
    chk("nak_step", step, 16'h1234);
    chk("nak_run", run, 1);

    frame(8'h03, 8'h02, 1);
    wait_tx(r);
    frame(8'h10, 8'h00, 1);
    wait_tx(r);
    chk("status", r, 8'hC0);

    k = got.size();
    send(8'hA5);
    send(8'h01);
    repeat (T + 10) cyc();
    chk("to_silent", got.size(), k);
    frame(8'h03, 8'h03, 0);
    wait_tx(r);
    chk("to_ack", r, 8'h06);
    chk("to_amp", amp_shift, 3);
    repeat (5) cyc();
    chk("to_one_resp", got.size(), k + 1);

    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom % 9)
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3: c = 8'h04;
        4: c = 8'h05;
        5: c = 8'h06;
        6: c = 8'h10;
        7: c = 8'($urandom);
        default: c = 8'h04;
      endcase
      d = 8'($urandom);
      if (c == 8'h06) d = 8'($urandom % 2);
      if ($urandom % 8 == 0) send(8'($urandom));
      frame(c, d, 3);
      repeat ($urandom_range(0, 40)) cyc();
    end
    rnd_rdy = 0;
    bus.tx_ready = 1'b1;
    repeat (10) cyc();

    bus.tx_ready = 1'b0;
    frame(8'h04, 8'h00, 0);
    repeat (3) cyc();
    frame(8'h04, 8'h01, 0);
    repeat (40) cyc();
    chk("bp_valid", bus.tx_valid, 1);
    chk("bp_data", bus.tx_data, 8'h06);
    chk("bp_run", run, 0);
    bus.tx_ready = 1'b1;
    repeat (3) cyc();
    chk("bp_drop", bus.tx_valid, 0);

    bus.tx_ready = 1'b0;
    frame(8'h03, 8'h01, 0);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("mr_txv", bus.tx_valid, 0);
    chk("mr_txd", bus.tx_data, 8'h00);
    chk("mr_step", step, 16'h0100);
    chk("mr_amp", amp_shift, 0);
    chk("mr_run", run, 0);
    chk("mr_tick", sample_tick, 0);
    cyc();
    rst_n = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (2) cyc();
    frame(8'h10, 8'h00, 0);
    wait_tx(r);
    chk("mr_status", r, 8'h00);
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_uart_ctrl.md
# sine_uart_ctrl

UART command controller for the PWM sine generator. It parses 3-byte command frames from the UART receiver and writes the generator's configuration registers: phase step, amplitude shift, run enable and sample prescaler. It answers each frame with one status byte through the UART transmitter. It also produces the sample-rate tick that advances the sine phase accumulator, and sits between the UART RX/TX pair and the PWM sine datapath inside the top-level wrapper.

## Interface
- TIMEOUT_CYCLES, 100000: max idle cycles between bytes of one frame before the partial frame is discarded.
- PRESC_RST, 16'd999: reset value of the sample prescaler reload.
- STEP_RST, 16'h0100: reset value of the phase step.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  response byte; held stable while tx_valid=1.
- tx_valid  out  1  response pending.
- tx_ready  in  1  transmitter accepts; transfer occurs when tx_valid&tx_ready.
- step  out  16  phase accumulator increment.
- amp_shift  out  2  amplitude attenuation (right shift 0..3).
- run  out  1  generator enable.
- sample_tick  out  1  one-cycle phase-advance strobe.

## Operation
- Frame format: 0xA5 header, command byte, data byte.
- FSM states: IDLE, CMD, DATA, RESP.
  - IDLE: rx byte 0xA5 -> CMD; any other byte is ignored.
  - CMD: latch the byte as cmd -> DATA.
  - DATA: execute the command -> RESP.
  - RESP: tx_valid=1 until the handshake completes -> IDLE.
- Commands:
  - 0x01 STEP_LO: step_shadow <= data; step unchanged.
  - 0x02 STEP_HI: step <= {data, step_shadow}. Both bytes change atomically.
  - 0x03 AMP: amp_shift <= data[1:0].
  - 0x04 RUN: run <= data[0].
  - 0x05 PRESC_LO: presc_shadow <= data.
  - 0x06 PRESC_HI: presc <= {data, presc_shadow}.
  - 0x10 STATUS: no register write.
- Response byte:
  - STATUS: {run, amp_shift, 5'b0}.
  - Other known commands: ACK 0x06.
  - Unknown command: NAK 0x15, and no register changes.
- Prescaler: the down-counter reloads with presc. sample_tick=1 for one cycle when the counter is 0 and run=1. Tick period is presc+1 cycles; presc=0 gives a tick every cycle.
- Writing presc reloads the counter on the next cycle, so the new period starts at once.
- run=0 holds the counter at presc and sample_tick at 0.

## Timing
- Reset values: state=IDLE, tx_valid=0, tx_data=0, step=STEP_RST, step_shadow=0, amp_shift=0, run=0, presc=PRESC_RST, presc_shadow=0, counter=PRESC_RST, sample_tick=0.
- Configuration outputs update on the clock edge after the data byte's rx_valid cycle.
- tx_valid rises in the same cycle as the configuration update.
- Frame latency: data byte strobe to tx_valid is 1 cycle.
- tx_data must not change while tx_valid=1 and tx_ready=0.
- tx_valid drops in the cycle after the handshake.
- Bytes arriving in RESP are dropped and do not start a frame. The next 0xA5 after the return to IDLE is honored.
- Timeout: a gap counter clears on each accepted byte in CMD or DATA. When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE with no response and no write.
- Simultaneous events:
  - A presc write in the same cycle as a counter reload: the new presc wins.
  - A run 1->0 write in a tick cycle: that tick is still issued, and none after it.
- Reset mid-frame or mid-RESP returns every output to its reset value immediately. The pending response is lost.

## Structure
- Shared package sine_uart_pkg holds:
  - command codes: CMD_STEP_LO..CMD_STATUS;
  - constants HDR=8'hA5, ACK=8'h06, NAK=8'h15;
  - the FSM state enum.
- One natural sub-module: sample_prescaler. It takes clk, rst_n, presc, load and run, and outputs sample_tick.
- Frame parsing, the register file and the response logic stay in the top of this block.

## Test plan
- Reset, then run=1 via A5 04 01: ACK 0x06 returned. With presc=999, sample_tick pulses every 1000 cycles, one cycle wide.
- A5 01 34 then A5 02 12: step stays 0x0100 after the first frame and becomes 0x1234 after the second. Two ACKs returned.
- A5 7E 00: NAK 0x15 returned; step, amp_shift, run and presc are unchanged.
- A5 03 02, then A5 10 00 with run=1: the STATUS response is 8'b1100_0000.
- A5, 01, then silence for TIMEOUT_CYCLES cycles, then A5 03 03: no response to the partial frame; amp_shift=3 with a single ACK.
- Hold tx_ready=0 for 50 cycles during RESP while sending A5 04 00: tx_data stays 0x06, the extra bytes are ignored, and run is unchanged until the next frame. Then assert rst_n=0 mid-RESP: tx_valid=0 and all registers return to reset values.
